uart_tx_fifo_drain: RTL

UART transmitter that drains the single-clock byte FIFO sitting directly upstream of it. When the FIFO reports non-empty, it pops one word and serialises it onto the TX line. Framing is 8N1 by default, with optional parity and 2 stop bits. It is used as the peripheral-side back end of the debug/console UART.

---
 rtl/uart_tx_fifo_drain.sv | 172 +++++++++++++++++
 1 files changed

// File: rtl/uart_tx_fifo_drain.sv
// uart_tx_fifo_drain
//   UART transmitter that pops bytes from the single-clock FIFO directly
//   upstream of it and serialises each one onto the TX line. A frame is a
//   start bit, DATA_BITS data bits (LSB first), an optional parity bit and
//   STOP_BITS stop bits. Every bit lasts exactly CLKS_PER_BIT clocks.
//
// Ports
//   i_Clock        system clock, rising edge
//   i_Reset        synchronous active-high reset
//   i_Enable       low: no new frame is started (a frame in flight completes)
//   i_FifoData     FIFO read data, valid the cycle after a read strobe
//   i_FifoEmpty    FIFO empty flag
//   o_FifoRdEnable one-cycle read strobe per word
//   o_Tx           serial line, idle high
//   o_Busy         high from FETCH through the last stop bit
//
// State | Meaning
// ------+-----------------------------------------------------------
// IDLE  | line high, waiting for enable and a non-empty FIFO
// FETCH | read strobe high for one cycle
// LOAD  | strobe low, FIFO data captured, parity computed
// START | start bit (line low)
// DATA  | data bits, LSB first
// PARITY| parity bit (only when PARITY != 0)
// STOP  | stop bit(s); then fetch the next word or go idle
module uart_tx_fifo_drain #(
  parameter int DATA_BITS    = 8,
  parameter int CLKS_PER_BIT = 868,
  parameter int PARITY       = 0,
  parameter int STOP_BITS    = 1
) (
  input  logic                 i_Clock,
  input  logic                 i_Reset,
  input  logic                 i_Enable,
  input  logic [DATA_BITS-1:0] i_FifoData,
  input  logic                 i_FifoEmpty,
  output logic                 o_FifoRdEnable,
  output logic                 o_Tx,
  output logic                 o_Busy
);

  localparam int BAUD_W = $clog2(CLKS_PER_BIT);
  localparam int BIT_W  = $clog2(DATA_BITS);

  localparam logic [BAUD_W-1:0] BAUD_LAST = BAUD_W'(CLKS_PER_BIT - 1);
  localparam logic [BIT_W-1:0]  DATA_LAST = BIT_W'(DATA_BITS - 1);
  localparam logic [BIT_W-1:0]  STOP_LAST = BIT_W'(STOP_BITS - 1);

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_FETCH,
    ST_LOAD,
    ST_START,
    ST_DATA,
    ST_PARITY,
    ST_STOP
  } stateType;

  stateType             state, stateNext;
  logic [BAUD_W-1:0]    baudCnt, baudCntNext;
  logic [BIT_W-1:0]     bitCnt, bitCntNext;
  logic [DATA_BITS-1:0] shiftReg, shiftRegNext;
  logic                 parityBit, parityBitNext;
  logic                 txNext, busyNext, rdEnableNext;
  logic                 baudEnd;
  logic                 wantFrame;

  assign baudEnd   = (baudCnt == BAUD_LAST);
  assign wantFrame = i_Enable && !i_FifoEmpty;

  // State, datapath and output registers. Outputs are loaded from the
  // next-state decode so they line up with the state they belong to.
  always_ff @(posedge i_Clock) begin
    if (i_Reset) begin
      state          <= ST_IDLE;
      baudCnt        <= '0;
      bitCnt         <= '0;
      shiftReg       <= '0;
      parityBit      <= 1'b0;
      o_Tx           <= 1'b1;
      o_Busy         <= 1'b0;
      o_FifoRdEnable <= 1'b0;
    end else begin
      state          <= stateNext;
      baudCnt        <= baudCntNext;
      bitCnt         <= bitCntNext;
      shiftReg       <= shiftRegNext;
      parityBit      <= parityBitNext;
      o_Tx           <= txNext;
      o_Busy         <= busyNext;
      o_FifoRdEnable <= rdEnableNext;
    end
  end

  // Next-state and datapath decode.
  always_comb begin
    stateNext     = state;
    baudCntNext   = '0;
    bitCntNext    = bitCnt;
    shiftRegNext  = shiftReg;
    parityBitNext = parityBit;

    // Baud counter runs only in the timed states and wraps at every bit
    // boundary, so bit periods never drift.
    if (state inside {ST_START, ST_DATA, ST_PARITY, ST_STOP}) begin
      baudCntNext = baudEnd ? '0 : baudCnt + 1'b1;
    end

    case (state)
      ST_IDLE: begin
        bitCntNext = '0;
        if (wantFrame) stateNext = ST_FETCH;
      end
      ST_FETCH: begin
        stateNext = ST_LOAD;
      end
      ST_LOAD: begin
        shiftRegNext  = i_FifoData;
        parityBitNext = (PARITY == 1) ? ~^i_FifoData : ^i_FifoData;
        bitCntNext    = '0;
        stateNext     = ST_START;
      end
      ST_START: begin
        if (baudEnd) stateNext = ST_DATA;
      end
      ST_DATA: begin
        if (baudEnd) begin
          if (bitCnt == DATA_LAST) begin
            bitCntNext = '0;
            stateNext  = (PARITY != 0) ? ST_PARITY : ST_STOP;
          end else begin
            bitCntNext   = bitCnt + 1'b1;
            shiftRegNext = shiftReg >> 1;
          end
        end
      end
      ST_PARITY: begin
        if (baudEnd) stateNext = ST_STOP;
      end
      ST_STOP: begin
        if (baudEnd) begin
          if (bitCnt == STOP_LAST) begin
            bitCntNext = '0;
            // Back-to-back frames skip IDLE entirely.
            stateNext  = wantFrame ? ST_FETCH : ST_IDLE;
          end else begin
            bitCntNext = bitCnt + 1'b1;
          end
        end
      end
      default: begin
        stateNext = ST_IDLE;
      end
    endcase
  end

  // Output decode from the state being entered.
  always_comb begin
    txNext       = 1'b1;
    busyNext     = 1'b1;
    rdEnableNext = 1'b0;
    case (stateNext)
      ST_IDLE:   busyNext     = 1'b0;
      ST_FETCH:  rdEnableNext = 1'b1;
      ST_START:  txNext       = 1'b0;
      ST_DATA:   txNext       = shiftRegNext[0];
      ST_PARITY: txNext       = parityBitNext;
      default:   txNext       = 1'b1;
    endcase
  end

endmodule
